// File: rtl/conv_pkg.sv
// Shared definitions for the convolution engine: FSM encoding, pipeline tags and
// default parameter values.
package conv_pkg;

    localparam int unsigned LANES_DEF     = 4;
    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned ACC_W_DEF     = 40;
    localparam int unsigned ADDR_W_DEF    = 16;
    localparam int unsigned FRAC_BITS_DEF = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } conv_state_e;

    // Travels down the pipeline alongside each issued read.
    typedef struct packed {
        logic valid;
        logic first;
        logic last_tap;
        logic last_neuron;
    } tap_tag_t;

endpackage

// File: rtl/mac_tree.sv
// Lane-parallel signed multiply plus adder tree, with a registered full-precision sum.
module mac_tree #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 16,
    localparam int unsigned SUM_W = 2 * DATA_W + $clog2(LANES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LANES*DATA_W-1:0]  a_i,
    input  logic [LANES*DATA_W-1:0]  b_i,
    output logic signed [SUM_W-1:0]  sum_o
);

    logic signed [DATA_W-1:0]   av;
    logic signed [DATA_W-1:0]   bv;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [SUM_W-1:0]    sum_d;

    always_comb begin
        av    = '0;
        bv    = '0;
        prod  = '0;
        sum_d = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            av    = a_i[(LANES-1-i)*DATA_W +: DATA_W];
            bv    = b_i[(LANES-1-i)*DATA_W +: DATA_W];
            prod  = (2*DATA_W)'(av) * (2*DATA_W)'(bv);
            sum_d = sum_d + SUM_W'(prod);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_o <= '0;
        end else begin
            sum_o <= sum_d;
        end
    end

endmodule

// File: rtl/conv_engine.sv
// Fully-connected/conv layer engine: streams ifm and weight words through a MAC tree,
// accumulates per neuron, then scales, saturates and packs results into output words.
module conv_engine
    import conv_pkg::*;
#(
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [15:0]              cfg_taps,
    input  logic [15:0]              cfg_neurons,
    input  logic [ADDR_W-1:0]        cfg_ifm_base,
    input  logic [ADDR_W-1:0]        cfg_w_base,
    input  logic [ADDR_W-1:0]        cfg_out_base,
    input  logic [ADDR_W-1:0]        cfg_ifm_stride,
    input  logic                     cfg_relu,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     ifm_en,
    output logic                     w_en,
    output logic [ADDR_W-1:0]        ifm_addr,
    output logic [ADDR_W-1:0]        w_addr,
    input  logic [LANES*DATA_W-1:0]  ifm_data,
    input  logic [LANES*DATA_W-1:0]  w_data,
    output logic                     out_en,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [LANES*DATA_W-1:0]  out_data,
    output logic [LANES-1:0]         out_mask,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned SUM_W  = 2 * DATA_W + $clog2(LANES);
    localparam int unsigned WORD_W = LANES * DATA_W;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    conv_state_e state_q, state_d;

    logic [15:0]              taps_q, taps_d, neurons_q, neurons_d;
    logic [ADDR_W-1:0]        w_base_q, w_base_d, out_base_q, out_base_d, stride_q, stride_d;
    logic                     relu_q, relu_d;
    logic signed [DATA_W-1:0] bias_q, bias_d;

    logic [15:0]       t_q, t_d, n_q, n_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d, w_addr_q, w_addr_d;
    tap_tag_t          iss_q, iss_d, tag1_q, tag2_q;

    logic signed [SUM_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  acc_q, acc_d, shifted;
    logic [DATA_W-1:0]        res;

    logic [WORD_W-1:0] pack_q, pack_d, filled;
    logic [LANES-1:0]  mask_fill;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic              out_en_q, out_en_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]  out_mask_q, out_mask_d;

    mac_tree #(
        .LANES  (LANES),
        .DATA_W (DATA_W)
    ) u_mac_tree (
        .clk   (clk),
        .rst   (rst),
        .a_i   (ifm_data),
        .b_i   (w_data),
        .sum_o (mac_sum)
    );

    // Control: config latch, tap/neuron counters and read issue.
    always_comb begin
        state_d    = state_q;
        taps_d     = taps_q;
        neurons_d  = neurons_q;
        w_base_d   = w_base_q;
        out_base_d = out_base_q;
        stride_d   = stride_q;
        relu_d     = relu_q;
        bias_d     = bias_q;
        t_d        = t_q;
        n_d        = n_q;
        row_d      = row_q;
        iss_d      = '0;
        ifm_addr_d = ifm_addr_q;
        w_addr_d   = w_addr_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StRun;
                    taps_d     = cfg_taps;
                    neurons_d  = cfg_neurons;
                    w_base_d   = cfg_w_base;
                    out_base_d = cfg_out_base;
                    stride_d   = cfg_ifm_stride;
                    relu_d     = cfg_relu;
                    bias_d     = bias;
                    t_d        = '0;
                    n_d        = '0;
                    row_d      = cfg_ifm_base;
                end
            end
            StRun: begin
                iss_d.valid       = 1'b1;
                iss_d.first       = (t_q == 16'd0);
                iss_d.last_tap    = (t_q == taps_q - 16'd1);
                iss_d.last_neuron = iss_d.last_tap && (n_q == neurons_q - 16'd1);
                ifm_addr_d        = row_q + ADDR_W'(t_q);
                w_addr_d          = w_base_q + ADDR_W'(t_q);
                if (iss_d.last_tap) begin
                    t_d   = '0;
                    n_d   = n_q + 16'd1;
                    row_d = row_q + stride_q;
                    if (iss_d.last_neuron) begin
                        state_d = StDrain;
                    end
                end else begin
                    t_d = t_q + 16'd1;
                end
            end
            StDrain: begin
                if (!(iss_q.valid || tag1_q.valid || tag2_q.valid)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath: accumulate, scale/saturate/ReLU, then pack lanes into output words.
    always_comb begin
        acc_d = acc_q;
        if (tag2_q.valid) begin
            acc_d = (tag2_q.first ? (ACC_W'(bias_q) <<< FRAC_BITS) : acc_q) + ACC_W'(mac_sum);
        end
        shifted = acc_d >>> FRAC_BITS;
        if (shifted > SAT_MAX) begin
            res = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            res = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res = shifted[DATA_W-1:0];
        end
        if (relu_q && res[DATA_W-1]) begin
            res = '0;
        end

        filled    = pack_q;
        mask_fill = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            if (LANE_W'(i) == lane_q) begin
                filled[(LANES-1-i)*DATA_W +: DATA_W] = res;
            end
            mask_fill[LANES-1-i] = (LANE_W'(i) <= lane_q);
        end

        pack_d     = pack_q;
        lane_d     = lane_q;
        word_d     = word_q;
        out_en_d   = 1'b0;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        out_mask_d = out_mask_q;
        if (state_q == StIdle && start) begin
            pack_d = '0;
            lane_d = '0;
            word_d = '0;
        end else if (tag2_q.valid && tag2_q.last_tap) begin
            if (lane_q == LANE_W'(LANES - 1) || tag2_q.last_neuron) begin
                out_en_d   = 1'b1;
                out_addr_d = out_base_q + word_q;
                out_data_d = filled;
                out_mask_d = mask_fill;
                word_d     = word_q + ADDR_W'(1);
                pack_d     = '0;
                lane_d     = '0;
            end else begin
                pack_d = filled;
                lane_d = lane_q + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            taps_q     <= '0;
            neurons_q  <= '0;
            w_base_q   <= '0;
            out_base_q <= '0;
            stride_q   <= '0;
            relu_q     <= 1'b0;
            bias_q     <= '0;
            t_q        <= '0;
            n_q        <= '0;
            row_q      <= '0;
            iss_q      <= '0;
            ifm_addr_q <= '0;
            w_addr_q   <= '0;
            tag1_q     <= '0;
            tag2_q     <= '0;
            acc_q      <= '0;
            pack_q     <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            out_en_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            out_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            taps_q     <= taps_d;
            neurons_q  <= neurons_d;
            w_base_q   <= w_base_d;
            out_base_q <= out_base_d;
            stride_q   <= stride_d;
            relu_q     <= relu_d;
            bias_q     <= bias_d;
            t_q        <= t_d;
            n_q        <= n_d;
            row_q      <= row_d;
            iss_q      <= iss_d;
            ifm_addr_q <= ifm_addr_d;
            w_addr_q   <= w_addr_d;
            tag1_q     <= iss_q;
            tag2_q     <= tag1_q;
            acc_q      <= acc_d;
            pack_q     <= pack_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            out_en_q   <= out_en_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            out_mask_q <= out_mask_d;
        end
    end

    always_comb begin
        ifm_en   = iss_q.valid;
        w_en     = iss_q.valid;
        ifm_addr = ifm_addr_q;
        w_addr   = w_addr_q;
        out_en   = out_en_q;
        out_addr = out_addr_q;
        out_data = out_data_q;
        out_mask = out_mask_q;
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
    end

endmodule

// File: tb/tb_conv_engine.sv
// Scoreboard bench for conv_engine: directed runs push expected writes, a monitor checks them.
module tb_conv_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_taps, cfg_neurons;
    logic [15:0] cfg_ifm_base, cfg_w_base, cfg_out_base, cfg_ifm_stride;
    logic        cfg_relu;
    logic [15:0] bias;
    logic        ifm_en, w_en, out_en, busy, done;
    logic [15:0] ifm_addr, w_addr, out_addr;
    logic [63:0] ifm_data = '0;
    logic [63:0] w_data = '0;
    logic [63:0] out_data;
    logic [3:0]  out_mask;

    logic [63:0] ifm_mem [0:65535];
    logic [63:0] w_mem   [0:65535];

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        logic [3:0]  mask;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [15:0] cap_q[$];
    int          wr_cyc_q[$];
    bit          cap_on = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          done_cyc = 0;

    always #5 clk = ~clk;

    conv_engine dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_taps       (cfg_taps),
        .cfg_neurons    (cfg_neurons),
        .cfg_ifm_base   (cfg_ifm_base),
        .cfg_w_base     (cfg_w_base),
        .cfg_out_base   (cfg_out_base),
        .cfg_ifm_stride (cfg_ifm_stride),
        .cfg_relu       (cfg_relu),
        .bias           (bias),
        .ifm_en         (ifm_en),
        .w_en           (w_en),
        .ifm_addr       (ifm_addr),
        .w_addr         (w_addr),
        .ifm_data       (ifm_data),
        .w_data         (w_data),
        .out_en         (out_en),
        .out_addr       (out_addr),
        .out_data       (out_data),
        .out_mask       (out_mask),
        .busy           (busy),
        .done           (done)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifm_en) ifm_data <= ifm_mem[ifm_addr];
        if (w_en) w_data <= w_mem[w_addr];
    end

    // Monitor: every write is popped against the scoreboard.
    always @(negedge clk) begin
        if (out_en) begin
            n_tests++;
            last_wr_cyc = cyc;
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write addr=%h data=%h mask=%b", out_addr, out_data,
                         out_mask);
            end else begin
                e = exp_q.pop_front();
                if (out_addr !== e.addr || out_data !== e.data || out_mask !== e.mask) begin
                    n_fail++;
                    $display("FAIL write got addr=%h data=%h mask=%b want addr=%h data=%h mask=%b",
                             out_addr, out_data, out_mask, e.addr, e.data, e.mask);
                end
            end
        end
        if (cap_on && ifm_en) cap_q.push_back(ifm_addr);
    end

    function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
        return {a, b, c, d};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [63:0] d, input logic [3:0] m);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.mask = m;
        exp_q.push_back(w);
    endtask

    task automatic fill(input bit is_w, input logic [15:0] base, input int count,
                        input logic [63:0] word);
        logic [15:0] a;
        for (int i = 0; i < count; i++) begin
            a = base + 16'(i);
            if (is_w) w_mem[a] = word;
            else ifm_mem[a] = word;
        end
    endtask

    task automatic start_run(input logic [15:0] taps, input logic [15:0] neurons,
                             input logic [15:0] ifmb, input logic [15:0] stride,
                             input logic [15:0] wb, input logic [15:0] outb,
                             input logic relu, input logic [15:0] b);
        cfg_taps       = taps;
        cfg_neurons    = neurons;
        cfg_ifm_base   = ifmb;
        cfg_ifm_stride = stride;
        cfg_w_base     = wb;
        cfg_out_base   = outb;
        cfg_relu       = relu;
        bias           = b;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_done_timeout got=0 want=1", name);
        end else begin
            done_cyc = cyc;
            check({name, "_done_after_write"}, 128'(done_cyc), 128'(last_wr_cyc + 1));
        end
        @(negedge clk);
        check({name, "_busy_after_done"}, 128'(busy), 128'(0));
        check({name, "_all_writes_seen"}, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic run(input string name, input logic [15:0] taps, input logic [15:0] neurons,
                       input logic [15:0] ifmb, input logic [15:0] stride,
                       input logic [15:0] wb, input logic [15:0] outb,
                       input logic relu, input logic [15:0] b);
        start_run(taps, neurons, ifmb, stride, wb, outb, relu, b);
        wait_done(name);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_taps = '0; cfg_neurons = '0; cfg_ifm_base = '0; cfg_w_base = '0;
        cfg_out_base = '0; cfg_ifm_stride = '0; cfg_relu = 1'b0; bias = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {busy, done, out_en, ifm_en, w_en, ifm_addr, w_addr, out_addr,
                              out_data, out_mask}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Basic: 4 neurons x 2 taps of 1.0*1.0 per lane -> 8.0 each.
        fill(0, 16'h1000, 10, pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        fill(1, 16'h2000, 2, pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        expect_wr(16'h0040, pack4(16'h0800, 16'h0800, 16'h0800, 16'h0800), 4'b1111);
        run("basic4", 16'd2, 16'd4, 16'h1000, 16'd2, 16'h2000, 16'h0040, 1'b0, 16'h0000);

        // Partial final word.
        expect_wr(16'h0050, pack4(16'h0800, 16'h0800, 16'h0800, 16'h0800), 4'b1111);
        expect_wr(16'h0051, pack4(16'h0800, 16'h0000, 16'h0000, 16'h0000), 4'b1000);
        run("partial5", 16'd2, 16'd5, 16'h1000, 16'd2, 16'h2000, 16'h0050, 1'b0, 16'h0000);

        // Positive saturation.
        fill(0, 16'h3000, 8, pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
        fill(1, 16'h3100, 8, pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
        expect_wr(16'h0060, pack4(16'h7FFF, 16'h0000, 16'h0000, 16'h0000), 4'b1000);
        run("sat_pos", 16'd8, 16'd1, 16'h3000, 16'd8, 16'h3100, 16'h0060, 1'b0, 16'h0000);

        // Negative result: ReLU clamps, otherwise saturates to min.
        fill(0, 16'h3200, 1, pack4(16'h8000, 16'h8000, 16'h8000, 16'h8000));
        fill(1, 16'h3300, 1, pack4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
        expect_wr(16'h0061, pack4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 4'b1000);
        run("relu", 16'd1, 16'd1, 16'h3200, 16'd1, 16'h3300, 16'h0061, 1'b1, 16'h0000);
        expect_wr(16'h0062, pack4(16'h8000, 16'h0000, 16'h0000, 16'h0000), 4'b1000);
        run("sat_neg", 16'd1, 16'd1, 16'h3200, 16'd1, 16'h3300, 16'h0062, 1'b0, 16'h0000);

        // taps=1: a neuron completes every cycle; bias 5 lands unshifted in the output.
        for (int i = 0; i < 8; i++) begin
            ifm_mem[16'h4000 + 16'(i)] = pack4(16'((i + 1) * 256), 16'h0100, 16'h0000, 16'h0000);
        end
        fill(1, 16'h4100, 1, pack4(16'h0100, 16'h0200, 16'h0300, 16'h0000));
        expect_wr(16'h0070, pack4(16'h0305, 16'h0405, 16'h0505, 16'h0605), 4'b1111);
        expect_wr(16'h0071, pack4(16'h0705, 16'h0805, 16'h0905, 16'h0A05), 4'b1111);
        wr_cyc_q.delete();
        run("taps1", 16'd1, 16'd8, 16'h4000, 16'd1, 16'h4100, 16'h0070, 1'b0, 16'h0005);
        check("taps1_write_count", 128'(wr_cyc_q.size()), 128'(2));
        if (wr_cyc_q.size() == 2) begin
            check("taps1_no_bubble", 128'(wr_cyc_q[1] - wr_cyc_q[0]), 128'(4));
        end

        // Negative bias and arithmetic right shift: -385 = 0xFE7F.
        fill(0, 16'h5000, 3, pack4(16'hFF00, 16'h0100, 16'h0000, 16'h0000));
        fill(1, 16'h5100, 3, pack4(16'h0100, 16'h0080, 16'h0000, 16'h0000));
        expect_wr(16'h0080, pack4(16'hFE7F, 16'h0000, 16'h0000, 16'h0000), 4'b1000);
        run("neg_shift", 16'd3, 16'd1, 16'h5000, 16'd3, 16'h5100, 16'h0080, 1'b0, 16'hFFFF);

        // Address wrap, plus a start pulse with different config while busy.
        fill(0, 16'hFFFE, 4, pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        fill(1, 16'h0200, 2, pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        expect_wr(16'h0090, pack4(16'h0800, 16'h0800, 16'h0800, 16'h0000), 4'b1110);
        cap_q.delete();
        cap_on = 1'b1;
        start_run(16'd2, 16'd3, 16'hFFFE, 16'd1, 16'h0200, 16'h0090, 1'b0, 16'h0000);
        repeat (2) @(negedge clk);
        check("busy_in_run", 128'(busy), 128'(1));
        cfg_taps = 16'd1; cfg_neurons = 16'd1; cfg_out_base = 16'h00A0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("wrap");
        cap_on = 1'b0;
        check("wrap_read_count", 128'(cap_q.size()), 128'(6));
        if (cap_q.size() == 6) begin
            check("wrap_addrs", {cap_q[0], cap_q[1], cap_q[2], cap_q[3], cap_q[4], cap_q[5]},
                  128'({16'hFFFE, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001}));
        end

        // Reset mid-run: outputs clear immediately, aborted run never writes.
        fill(0, 16'h6000, 64, pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        fill(1, 16'h6100, 8, pack4(16'h0100, 16'h0100, 16'h0100, 16'h0100));
        start_run(16'd8, 16'd8, 16'h6000, 16'd8, 16'h6100, 16'h00B0, 1'b0, 16'h0000);
        repeat (10) @(negedge clk);
        check("busy_before_abort", 128'(busy), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("reset_midrun", {busy, done, out_en, ifm_en, w_en, ifm_addr, w_addr, out_addr,
                               out_data, out_mask}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("abort_idle", 128'(busy), 128'(0));
        expect_wr(16'h00C0, pack4(16'h0800, 16'h0800, 16'h0800, 16'h0800), 4'b1111);
        run("after_reset", 16'd2, 16'd4, 16'h1000, 16'd2, 16'h2000, 16'h00C0, 1'b0, 16'h0000);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
